// File: rtl/mac_rob_pkg.sv
// Shared sizing, FSM encoding and pending-row record for the MAC reorder drain scheduler.
package mac_rob_pkg;

    localparam int ROW_W     = 11;
    localparam int ENTRIES   = 8;
    localparam int WAYS      = 8;
    localparam int AGE_W     = 8;
    localparam int AGE_LIMIT = 200;
    localparam int DRAIN_TMO = 32;

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int CNT_W  = $clog2(WAYS + 1);
    localparam int TMR_W  = $clog2(DRAIN_TMO);
    localparam int ITEM_W = $clog2(DRAIN_TMO + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DRAIN,
        ST_RETIRE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [CNT_W-1:0] cnt;
        logic [AGE_W-1:0] age;
        logic             lock;
    } entry_t;

endpackage

// File: rtl/rob_row_scheduler_if.sv
// Enqueue, open-row, ROB read/item and status signals of the drain scheduler.
interface rob_row_scheduler_if;
    import mac_rob_pkg::*;

    logic             enq_valid;
    logic [ROW_W-1:0] enq_row;
    logic             enq_ready;
    logic             drain_en;
    logic             open_row_valid;
    logic [ROW_W-1:0] open_row;
    logic             rob_rd;
    logic [ROW_W-1:0] rob_row;
    logic             item_valid;
    logic             item_end;
    logic             busy;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output enq_valid, enq_row, drain_en, open_row_valid, open_row, item_valid, item_end,
        input  enq_ready, rob_rd, rob_row, busy, full, empty, err
    );

    modport slave (
        input  enq_valid, enq_row, drain_en, open_row_valid, open_row, item_valid, item_end,
        output enq_ready, rob_rd, rob_row, busy, full, empty, err
    );

endinterface

// File: rtl/rob_sched_pick.sv
// Combinational picker: full rows, then starving rows by age, then the open row, then oldest.
// Ties resolve to the lowest index; locked or invalid entries never win.
module rob_sched_pick
    import mac_rob_pkg::*;
(
    input  entry_t           ents [ENTRIES],
    input  logic             open_row_valid,
    input  logic [ROW_W-1:0] open_row,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Two class bits above an age field; strict '>' keeps the lowest index on ties.
    logic [AGE_W+1:0] key;
    logic [AGE_W+1:0] best;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        best  = '0;
        key   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ents[i].cnt == CNT_W'(WAYS))
                key = {2'd3, {AGE_W{1'b0}}};
            else if (ents[i].age >= AGE_W'(AGE_LIMIT))
                key = {2'd2, ents[i].age};
            else if (open_row_valid && (ents[i].row == open_row))
                key = {2'd1, {AGE_W{1'b0}}};
            else
                key = {2'd0, ents[i].age};
            if (ents[i].valid && !ents[i].lock && (!found || (key > best))) begin
                best  = key;
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_row_scheduler.sv
// Pending-row table plus drain FSM; read pulse 2 cycles after leaving IDLE.
// enq_ready drops when the table is full, the row is locked, or its ways are used up.
module rob_row_scheduler
    import mac_rob_pkg::*;
(
    input logic                clk,
    input logic                resetn,
    rob_row_scheduler_if.slave bus
);

    entry_t              ents [ENTRIES];
    state_t              state;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_found;
    logic [ITEM_W-1:0]   item_cnt;
    logic [TMR_W-1:0]    timer;
    logic                rob_rd_q;
    logic [ROW_W-1:0]    rob_row_q;
    logic                busy_q;
    logic                err_q;

    logic [ENTRIES-1:0]  vld;
    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;
    logic                free_hit;
    logic [IDX_W-1:0]    free_idx;
    logic                enq_ready;
    logic                enq_fire;

    // Descending scan so the lowest matching / free index is the one left standing.
    always_comb begin
        vld       = '0;
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            vld[i] = ents[i].valid;
            if (ents[i].valid && (ents[i].row == bus.enq_row)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!ents[i].valid) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign enq_ready = match_hit ? (!ents[match_idx].lock && (ents[match_idx].cnt < CNT_W'(WAYS)))
                                 : free_hit;
    assign enq_fire  = bus.enq_valid && enq_ready;

    rob_sched_pick u_pick (
        .ents           (ents),
        .open_row_valid (bus.open_row_valid),
        .open_row       (bus.open_row),
        .idx            (pick_idx),
        .found          (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) ents[i] <= '0;
            state     <= ST_IDLE;
            win_idx   <= '0;
            item_cnt  <= '0;
            timer     <= '0;
            rob_rd_q  <= 1'b0;
            rob_row_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (ents[i].valid && !ents[i].lock && (ents[i].age != '1))
                    ents[i].age <= ents[i].age + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.drain_en && (|vld)) begin
                        state  <= ST_SELECT;
                        busy_q <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (pick_found) begin
                        win_idx             <= pick_idx;
                        ents[pick_idx].lock <= 1'b1;
                        rob_rd_q            <= 1'b1;
                        rob_row_q           <= ents[pick_idx].row;
                        state               <= ST_ISSUE;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    rob_rd_q <= 1'b0;
                    item_cnt <= '0;
                    timer    <= '0;
                    state    <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (bus.item_valid) item_cnt <= item_cnt + 1'b1;
                    if (bus.item_end) begin
                        state <= ST_RETIRE;
                    end else if (timer == TMR_W'(DRAIN_TMO - 1)) begin
                        err_q <= 1'b1;
                        state <= ST_RETIRE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RETIRE: begin
                    ents[win_idx].valid <= 1'b0;
                    ents[win_idx].lock  <= 1'b0;
                    if (item_cnt != ITEM_W'(ents[win_idx].cnt)) err_q <= 1'b1;
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // Enqueue decisions use the pre-edge table, so a retiring slot is reusable next cycle.
            if (enq_fire) begin
                if (match_hit)
                    ents[match_idx].cnt <= ents[match_idx].cnt + 1'b1;
                else
                    ents[free_idx] <= '{valid: 1'b1, row: bus.enq_row, cnt: CNT_W'(1),
                                        age: '0, lock: 1'b0};
            end
        end
    end

    assign bus.enq_ready = enq_ready;
    assign bus.rob_rd    = rob_rd_q;
    assign bus.rob_row   = rob_row_q;
    assign bus.busy      = busy_q;
    assign bus.full      = &vld;
    assign bus.empty     = ~|vld;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_rob_row_scheduler.sv
// Directed scenarios plus randomized traffic, every cycle checked against a table-level model.
module tb_rob_row_scheduler;
    import mac_rob_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    rob_row_scheduler_if bus ();

    rob_row_scheduler dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the pending-row table as plain arrays, and the drain as a cycle count
    // since leaving idle (1 = choosing, 2 = read issued, 3.. = waiting on items, -1 = retiring).
    bit m_v   [ENTRIES];
    int m_row [ENTRIES];
    int m_cnt [ENTRIES];
    int m_age [ENTRIES];
    bit m_lk  [ENTRIES];
    int m_dcyc, m_win, m_items, m_out_row;
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i] = 0; m_row[i] = 0; m_cnt[i] = 0; m_age[i] = 0; m_lk[i] = 0;
        end
        m_dcyc = 0; m_win = 0; m_items = 0; m_out_row = 0; m_err = 0;
    endfunction

    function automatic int find_row(input int row);
        for (int i = 0; i < ENTRIES; i++) if (m_v[i] && m_row[i] == row) return i;
        return -1;
    endfunction

    function automatic int find_free();
        for (int i = 0; i < ENTRIES; i++) if (!m_v[i]) return i;
        return -1;
    endfunction

    function automatic bit exp_ready();
        int m;
        m = find_row(int'(bus.enq_row));
        if (m >= 0) return !m_lk[m] && (m_cnt[m] < WAYS);
        return find_free() >= 0;
    endfunction

    function automatic int pick();
        int w;
        w = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && !m_lk[i] && m_cnt[i] == WAYS) return i;
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && !m_lk[i] && m_age[i] >= AGE_LIMIT && (w < 0 || m_age[i] > m_age[w])) w = i;
        if (w >= 0) return w;
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && !m_lk[i] && bus.open_row_valid && m_row[i] == int'(bus.open_row)) return i;
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && !m_lk[i] && (w < 0 || m_age[i] > m_age[w])) w = i;
        return w;
    endfunction

    function automatic int n_valid();
        int n;
        n = 0;
        for (int i = 0; i < ENTRIES; i++) n += m_v[i];
        return n;
    endfunction

    task automatic compare();
        check("enq_ready", bus.enq_ready, exp_ready());
        check("rob_rd", bus.rob_rd, m_dcyc == 2);
        if (m_dcyc == 2) check("rob_row", bus.rob_row, m_out_row);
        check("busy", bus.busy, m_dcyc != 0);
        check("full", bus.full, n_valid() == ENTRIES);
        check("empty", bus.empty, n_valid() == 0);
        check("err", bus.err, m_err);
    endtask

    task automatic model_step();
        int w, mi, fi;
        bit acc;
        if (!resetn) begin
            model_reset();
            return;
        end
        w   = pick();
        acc = bus.enq_valid && exp_ready();
        mi  = find_row(int'(bus.enq_row));
        fi  = find_free();
        for (int i = 0; i < ENTRIES; i++)
            if (m_v[i] && !m_lk[i] && m_age[i] < 255) m_age[i]++;
        if (m_dcyc == 0) begin
            if (bus.drain_en && n_valid() > 0) m_dcyc = 1;
        end else if (m_dcyc == 1) begin
            if (w >= 0) begin
                m_win = w; m_lk[w] = 1; m_out_row = m_row[w]; m_dcyc = 2;
            end else m_dcyc = 0;
        end else if (m_dcyc == 2) begin
            m_items = 0; m_dcyc = 3;
        end else if (m_dcyc == -1) begin
            m_v[m_win] = 0; m_lk[m_win] = 0;
            if (m_items != m_cnt[m_win]) m_err = 1;
            m_dcyc = 0;
        end else begin
            if (bus.item_valid) m_items++;
            if (bus.item_end) m_dcyc = -1;
            else if (m_dcyc - 2 == DRAIN_TMO) begin m_err = 1; m_dcyc = -1; end
            else m_dcyc++;
        end
        if (acc) begin
            if (mi >= 0) m_cnt[mi]++;
            else begin
                m_v[fi] = 1; m_row[fi] = int'(bus.enq_row); m_cnt[fi] = 1; m_age[fi] = 0; m_lk[fi] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.enq_valid = 0; bus.enq_row = '0; bus.drain_en = 0;
        bus.open_row_valid = 0; bus.open_row = '0; bus.item_valid = 0; bus.item_end = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic enq(input int row);
        bus.enq_valid = 1; bus.enq_row = ROW_W'(row);
        tick();
        bus.enq_valid = 0;
    endtask

    task automatic wait_rd(input int exp_row);
        int n;
        n = 0;
        while (bus.rob_rd !== 1'b1 && n < 20) begin tick(); n++; end
        check("rd_seen", bus.rob_rd, 1);
        check("rd_row", bus.rob_row, exp_row);
    endtask

    task automatic finish_drain(input int beats);
        tick();
        repeat (beats) begin bus.item_valid = 1; tick(); end
        bus.item_valid = 0; bus.item_end = 1;
        tick();
        bus.item_end = 0;
        tick();
    endtask

    int plan_beats;
    bit plan_end;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        clear_inputs();
        resetn = 0;
        @(posedge clk); #1;
        resetn = 1;
        check("rst_busy", bus.busy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_err", bus.err, 0);
        check("rst_rd", bus.rob_rd, 0);
        check("rst_row", bus.rob_row, 0);

        // Oldest row drains first, then the remaining one.
        enq('h010); enq('h010); enq('h010); enq('h020);
        bus.drain_en = 1;
        wait_rd('h010);
        finish_drain(3);
        check("t1_err", bus.err, 0);
        wait_rd('h020);
        bus.drain_en = 0;
        finish_drain(1);
        check("t1_err2", bus.err, 0);
        check("t1_empty", bus.empty, 1);

        // A row with all ways used refuses more and wins over an older entry.
        do_reset();
        enq('h011);
        repeat (8) enq('h055);
        bus.enq_valid = 1; bus.enq_row = ROW_W'('h055); #1;
        check("t2_ways_ready", bus.enq_ready, 0);
        bus.enq_valid = 0;
        bus.drain_en = 1;
        wait_rd('h055);
        finish_drain(8);
        wait_rd('h011);
        bus.drain_en = 0;
        finish_drain(1);
        check("t2_err", bus.err, 0);

        // Full table: new row refused, existing row still accepted.
        do_reset();
        for (int i = 0; i < ENTRIES; i++) enq('h100 + i);
        check("t3_full", bus.full, 1);
        bus.enq_row = ROW_W'('h1ff); #1;
        check("t3_new_ready", bus.enq_ready, 0);
        bus.enq_row = ROW_W'('h103); #1;
        check("t3_hit_ready", bus.enq_ready, 1);

        // Open row beats age, but a starving row beats the open row.
        do_reset();
        bus.open_row_valid = 1; bus.open_row = ROW_W'('h033);
        enq('h001);
        repeat (7) tick();
        enq('h033);
        tick();
        bus.drain_en = 1;
        wait_rd('h033);
        bus.drain_en = 0;
        finish_drain(1);
        do_reset();
        bus.open_row_valid = 1; bus.open_row = ROW_W'('h033);
        enq('h001);
        repeat (205) tick();
        enq('h033);
        bus.drain_en = 1;
        wait_rd('h001);
        bus.drain_en = 0;
        finish_drain(1);
        bus.open_row_valid = 0;

        // Missing item end times out, flags a sticky error and frees the row.
        do_reset();
        enq('h077);
        bus.drain_en = 1;
        wait_rd('h077);
        bus.drain_en = 0;
        tick();
        for (int n = 0; n < 60 && bus.busy; n++) tick();
        check("t5_err", bus.err, 1);
        check("t5_empty", bus.empty, 1);
        repeat (3) tick();
        check("t5_sticky", bus.err, 1);

        // Reset in the middle of a drain.
        do_reset();
        enq('h066);
        bus.drain_en = 1;
        wait_rd('h066);
        bus.drain_en = 0;
        tick(); tick();
        resetn = 0;
        tick();
        check("t6_busy", bus.busy, 0);
        check("t6_empty", bus.empty, 1);
        check("t6_err", bus.err, 0);
        check("t6_rd", bus.rob_rd, 0);
        resetn = 1;
        tick();
        check("t6_rd_after", bus.rob_rd, 0);

        // Randomized traffic over a small row set so hits, fills and races occur.
        do_reset();
        plan_beats = 0; plan_end = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.enq_valid      = ($urandom % 3) == 0;
            bus.enq_row        = ROW_W'('h200 + $urandom % 10);
            bus.drain_en       = ($urandom % 4) != 0;
            bus.open_row_valid = $urandom % 2;
            bus.open_row       = ROW_W'('h200 + $urandom % 10);
            resetn             = ($urandom % 400) != 0;
            if (m_dcyc == 2) begin
                plan_beats = (($urandom % 10) == 0) ? int'($urandom % 4) : m_cnt[m_win];
                plan_end   = ($urandom % 20) != 0;
            end
            if (m_dcyc >= 3) begin
                bus.item_end = 0;
                if (plan_beats > 0) begin
                    bus.item_valid = $urandom % 2;
                    if (bus.item_valid) plan_beats--;
                end else begin
                    bus.item_valid = 0;
                    bus.item_end   = plan_end;
                end
            end else begin
                bus.item_valid = ($urandom % 16) == 0;
                bus.item_end   = ($urandom % 16) == 0;
            end
            tick();
        end
        resetn = 1;
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_row_scheduler.md
Name: rob_row_scheduler

Overview:
Drain scheduler for the MAC reorder processor.
- Tracks which DRAM rows currently hold pending items in the ROB, and how many.
- Chooses the next row to drain and issues the ROB read command (row + read pulse).
- Sequences the drain until the ROB signals item end, then retires the row.
- Applies back-pressure to the request path when the row table, or a row's ways, are exhausted.

Parameters:
ROW_W, 11, DRAM row address width (matches ROB row width)
ENTRIES, 8, pending-row table depth
WAYS, 8, ROB ways per row (max items per row)
AGE_W, 8, per-entry age counter width
AGE_LIMIT, 200, age at which an entry becomes starvation-urgent
DRAIN_TMO, 32, max cycles from read issue to item end

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
iEnqValid  in  1  request written into ROB this cycle
iEnqRow  in  ROW_W  row of enqueued request
oEnqReady  out  1  enqueue accepted (combinational)
iDrainEn  in  1  allow new drain selection
iOpenRowValid  in  1  iOpenRow is currently open in the bank
iOpenRow  in  ROW_W  currently open row
oROB_Rd  out  1  one-cycle ROB read pulse
oROB_Row  out  ROW_W  row to read, valid with oROB_Rd
iROB_ItemValid  in  1  ROB item beat
iROB_ItemEnd  in  1  last item of row
oBusy  out  1  drain in progress (state != IDLE)
oFull  out  1  all entries valid
oEmpty  out  1  no entries valid
oErr  out  1  sticky: timeout or item-count mismatch

Behaviour:
- One clock: clk. Reset is synchronous and active-low (resetn).
- Reset values: all entries invalid; state IDLE; oROB_Rd=0; oROB_Row=0; oBusy=0; oFull=0; oEmpty=1; oErr=0.
- Entry fields: valid, row, cnt (1..WAYS), age, lock.
- Enqueue match: a valid entry with row==iEnqRow.
- oEnqReady=1 in exactly these cases:
  - match, not locked, and cnt<WAYS; or
  - no match and a free entry exists.
- Enqueue accepted at posedge when iEnqValid & oEnqReady:
  - On match: cnt+1.
  - Otherwise: allocate the lowest free index with cnt=1, age=0.
- Age: every valid, unlocked entry increments age each cycle, saturating at 2^AGE_W-1.
- FSM:
  - IDLE: if iDrainEn & ~oEmpty -> SELECT.
  - SELECT (1 cycle): register the winner index and set its lock.
  - ISSUE (1 cycle): oROB_Rd=1, oROB_Row=entry row; clear the item counter and timer -> DRAIN.
  - DRAIN: count iROB_ItemValid beats; the timer increments each cycle.
    - iROB_ItemEnd -> RETIRE.
    - Timer reaches DRAIN_TMO -> set oErr -> RETIRE.
  - RETIRE (1 cycle): clear valid and lock; if item count != cnt, set oErr -> IDLE.
- Selection priority (ties go to the lowest index):
  1. cnt==WAYS.
  2. age>=AGE_LIMIT, highest age first.
  3. iOpenRowValid and row==iOpenRow.
  4. Highest age.
- Simultaneous events:
  - Enqueue and RETIRE in the same cycle: the enqueue sees the pre-retire table. A freed slot is usable from the next cycle. An enqueue to the retiring row sees it locked (ready=0).
  - Enqueue during SELECT to the winning row: the lock is not yet visible, so the enqueue is accepted and increments cnt. The lock becomes effective the following cycle.
- iDrainEn deassert mid-drain has no effect; the current row completes.
- Reset asserted mid-drain: all state returns to reset values next edge; no oROB_Rd is generated.
- Latency: drain command issued 2 cycles after IDLE exit (SELECT, ISSUE). Minimum drain turnaround is ISSUE + ROB latency (3) + RETIRE.

Decomposition:
- Shared package mac_rob_pkg holds:
  - ROW_W, WAYS (from the existing ROW_W definition);
  - FSM state encoding (IDLE, SELECT, ISSUE, DRAIN, RETIRE);
  - the entry record type.
- One sub-module, rob_sched_pick: combinational priority picker.
  - Inputs: entry vector, open-row info.
  - Outputs: winner index and found flag.

Test Plan:
- Enqueue rows 0x010 x3 and 0x020 x1, then iDrainEn=1 -> oROB_Rd pulse with oROB_Row=0x010 (highest age, index 0). After ItemEnd following 3 ItemValid beats: oErr=0, then row 0x020 drained.
- Enqueue 8 items to row 0x055 -> oEnqReady=0 for a 9th to 0x055; the drain picks 0x055 over an older entry, row 0x011 cnt=1.
- Fill 8 distinct rows -> oFull=1, oEnqReady=0 for a new row and =1 for an existing unlocked row with cnt<8.
- iOpenRowValid=1, iOpenRow=0x033, entries 0x001 (age 10), 0x033 (age 2) -> 0x033 selected. With 0x001 age>=200 -> 0x001 selected.
- No iROB_ItemEnd after issue -> RETIRE at DRAIN_TMO=32 cycles, oErr=1 sticky, entry freed, oEmpty=1.
- resetn=0 during DRAIN -> next cycle oBusy=0, oEmpty=1, oErr=0, oROB_Rd stays 0.
